// File: rtl/pkt_steer_pkg.sv
// Shared constants, state/class encodings and the header classifier for pkt_steer_axis.
package pkt_steer_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0008;
    localparam logic [7:0]  IPPROT_UDP    = 8'h11;

    typedef enum logic [1:0] {ST_HDR, ST_REPLAY, ST_STREAM, ST_DROP} state_t;
    typedef enum logic [1:0] {CLS_DATA, CLS_CTRL, CLS_DROP} cls_t;

    // Field values are compared in wire byte order, exactly as they sit in tdata.
    function automatic cls_t classify(input logic [15:0] eth_type, input logic [7:0] prot,
                                      input logic [15:0] dport, input logic [15:0] ctrl_port);
        if (eth_type != ETH_TYPE_IPV4 || prot != IPPROT_UDP)
            return CLS_DROP;
        return (dport == ctrl_port) ? CLS_CTRL : CLS_DATA;
    endfunction

endpackage

// File: rtl/pkt_steer_axis_slot.sv
// axis_out_slot: single-entry AXI-Stream output register; payload held while valid && !ready.
module axis_out_slot
    import pkt_steer_pkg::*;
#(
    parameter int DW = 256,
    parameter int UW = 128
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            load,
    input  logic [DW-1:0]   ld_tdata,
    input  logic [DW/8-1:0] ld_tkeep,
    input  logic [UW-1:0]   ld_tuser,
    input  logic            ld_tlast,
    output logic            free,
    output logic [DW-1:0]   tdata,
    output logic [DW/8-1:0] tkeep,
    output logic [UW-1:0]   tuser,
    output logic            tvalid,
    output logic            tlast,
    input  logic            tready
);

    assign free = !tvalid || tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tkeep  <= '0;
            tuser  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= ld_tdata;
            tkeep  <= ld_tkeep;
            tuser  <= ld_tuser;
            tlast  <= ld_tlast;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pkt_steer_axis.sv
// Steers IPv4/UDP packets to the data or control AXIS port; drops everything else and runts.
// Define PKT_STEER_STATS_EN to add the stat_* packet counters.
//
// state   | meaning
// HDR     | accept and buffer header beats, classify on the last one
// REPLAY  | emit buffered header beats to the selected output
// STREAM  | pass remaining beats through the selected output slot
// DROP    | discard beats until tlast
module pkt_steer_axis
    import pkt_steer_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          HDR_BEATS            = 2,
    parameter int          ETH_TYPE_OFF         = 128,
    parameter int          IP_PROT_OFF          = 216,
    parameter int          UDP_DPORT_OFF        = 320,
    parameter logic [15:0] CTRL_PORT            = 16'hf2f1,
    parameter int          CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
    output logic                              ctrl_m_axis_tvalid,
    output logic                              ctrl_m_axis_tlast,
    input  logic                              ctrl_m_axis_tready
`ifdef PKT_STEER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]              stat_data_pkts,
    output logic [CNT_WIDTH-1:0]              stat_ctrl_pkts,
    output logic [CNT_WIDTH-1:0]              stat_drop_pkts
`endif
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int HW = HDR_BEATS * DW;
    localparam int CW = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(HDR_BEATS - 1);

    state_t                  state, state_nxt;
    cls_t                    cls, cls_now;
    logic [CW-1:0]           hdr_cnt, rep_idx;
    logic [HW-1:0]           hdr_data;
    logic [HDR_BEATS*KW-1:0] hdr_keep;
    logic [HDR_BEATS*UW-1:0] hdr_user;
    logic                    hdr_last;
    logic                    s_hs, last_hdr, data_free, ctrl_free, sel_free;
    logic                    ld, ld_data, ld_ctrl;
    logic [DW-1:0]           out_tdata;
    logic [KW-1:0]           out_tkeep;
    logic [UW-1:0]           out_tuser;
    logic                    out_tlast;

    // The final header beat is classified straight off the bus, before it lands in the buffer.
    function automatic logic [HW-1:0] hdr_view(input logic [HW-1:0] stored, input logic [DW-1:0] beat);
        logic [HW-1:0] h;
        h = stored;
        h[HW-DW +: DW] = beat;
        return h;
    endfunction

    function automatic cls_t classify_hdr(input logic [HW-1:0] h);
        return classify(h[ETH_TYPE_OFF +: 16], h[IP_PROT_OFF +: 8], h[UDP_DPORT_OFF +: 16], CTRL_PORT);
    endfunction

    assign s_hs     = s_axis_tvalid && s_axis_tready;
    assign last_hdr = (hdr_cnt == LAST_IDX);
    assign cls_now  = classify_hdr(hdr_view(hdr_data, s_axis_tdata));
    assign sel_free = (cls == CLS_CTRL) ? ctrl_free : data_free;
    assign ld_data  = ld && (cls == CLS_DATA);
    assign ld_ctrl  = ld && (cls == CLS_CTRL);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_HDR;
            hdr_cnt <= '0;
            rep_idx <= '0;
            cls     <= CLS_DROP;
        end else begin
            state <= state_nxt;
            if (state == ST_HDR && s_hs) begin
                if (last_hdr) begin
                    hdr_cnt <= '0;
                    rep_idx <= '0;
                    cls     <= cls_now;
                end else if (s_axis_tlast) begin
                    hdr_cnt <= '0;
                end else begin
                    hdr_cnt <= hdr_cnt + CW'(1);
                end
            end else if (state == ST_REPLAY && sel_free) begin
                rep_idx <= rep_idx + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_HDR && s_hs) begin
            hdr_data[hdr_cnt*DW +: DW] <= s_axis_tdata;
            hdr_keep[hdr_cnt*KW +: KW] <= s_axis_tkeep;
            hdr_user[hdr_cnt*UW +: UW] <= s_axis_tuser;
            hdr_last                   <= s_axis_tlast;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        ld            = 1'b0;
        out_tdata     = s_axis_tdata;
        out_tkeep     = s_axis_tkeep;
        out_tuser     = s_axis_tuser;
        out_tlast     = s_axis_tlast;
        case (state)
            ST_HDR: begin
                s_axis_tready = 1'b1;
                if (s_hs && last_hdr) begin
                    if (cls_now != CLS_DROP) state_nxt = ST_REPLAY;
                    else if (!s_axis_tlast)  state_nxt = ST_DROP;
                end
            end
            ST_REPLAY: begin
                out_tdata = hdr_data[rep_idx*DW +: DW];
                out_tkeep = hdr_keep[rep_idx*KW +: KW];
                out_tuser = hdr_user[rep_idx*UW +: UW];
                out_tlast = (rep_idx == LAST_IDX) && hdr_last;
                if (sel_free) begin
                    ld = 1'b1;
                    if (rep_idx == LAST_IDX) state_nxt = hdr_last ? ST_HDR : ST_STREAM;
                end
            end
            ST_STREAM: begin
                s_axis_tready = sel_free;
                if (s_hs) begin
                    ld = 1'b1;
                    if (s_axis_tlast) state_nxt = ST_HDR;
                end
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                if (s_hs && s_axis_tlast) state_nxt = ST_HDR;
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    axis_out_slot #(.DW(DW), .UW(UW)) u_data_slot (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (ld_data),
        .ld_tdata (out_tdata),
        .ld_tkeep (out_tkeep),
        .ld_tuser (out_tuser),
        .ld_tlast (out_tlast),
        .free     (data_free),
        .tdata    (m_axis_tdata),
        .tkeep    (m_axis_tkeep),
        .tuser    (m_axis_tuser),
        .tvalid   (m_axis_tvalid),
        .tlast    (m_axis_tlast),
        .tready   (m_axis_tready)
    );

    axis_out_slot #(.DW(DW), .UW(UW)) u_ctrl_slot (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (ld_ctrl),
        .ld_tdata (out_tdata),
        .ld_tkeep (out_tkeep),
        .ld_tuser (out_tuser),
        .ld_tlast (out_tlast),
        .free     (ctrl_free),
        .tdata    (ctrl_m_axis_tdata),
        .tkeep    (ctrl_m_axis_tkeep),
        .tuser    (ctrl_m_axis_tuser),
        .tvalid   (ctrl_m_axis_tvalid),
        .tlast    (ctrl_m_axis_tlast),
        .tready   (ctrl_m_axis_tready)
    );

`ifdef PKT_STEER_STATS_EN
    // Runts count as drops at their tlast; everything else counts once at classification.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_data_pkts <= '0;
            stat_ctrl_pkts <= '0;
            stat_drop_pkts <= '0;
        end else if (state == ST_HDR && s_hs) begin
            if (last_hdr) begin
                case (cls_now)
                    CLS_DATA: stat_data_pkts <= stat_data_pkts + 1'b1;
                    CLS_CTRL: stat_ctrl_pkts <= stat_ctrl_pkts + 1'b1;
                    default:  stat_drop_pkts <= stat_drop_pkts + 1'b1;
                endcase
            end else if (s_axis_tlast) begin
                stat_drop_pkts <= stat_drop_pkts + 1'b1;
            end
        end
    end
`endif

endmodule
